// File: rtl/icache_pkg.sv
// Shared widths and state encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned ICACHE_IDX_W = 6;
    localparam int unsigned ICACHE_TAG_W = 32 - 2 - ICACHE_IDX_W;
    localparam int unsigned ICACHE_LINES = 1 << ICACHE_IDX_W;
    localparam int unsigned ICACHE_WA_W  = 30;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_MISS = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data line storage: one combinational read port, one synchronous write port.
module icache_array
    import icache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ICACHE_IDX_W-1:0] idx,
    output logic                    valid,
    output logic [ICACHE_TAG_W-1:0] tag,
    output logic [31:0]             data,
    input  logic                    we,
    input  logic [ICACHE_IDX_W-1:0] widx,
    input  logic [ICACHE_TAG_W-1:0] wtag,
    input  logic [31:0]             wdata
);

    logic [ICACHE_LINES-1:0] valid_q;
    logic [ICACHE_TAG_W-1:0] tag_q  [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];

    // Only the valid bits need reset; tag/data are ignored while invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

    assign valid = valid_q[idx];
    assign tag   = tag_q[idx];
    assign data  = data_q[idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with a miss/refill handshake
// towards the memory controller and flush-based refill abandonment.
module icache
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        fetch_rdy,
    output logic [31:0] fetch_inst,
    output logic        inst_miss,
    output logic [31:0] pc,
    input  logic        inst_rdy,
    input  logic [31:0] inst_out
);

    icache_state_t           state_q, state_d;
    logic [ICACHE_WA_W-1:0]  miss_wa_q, miss_wa_d;
    logic [ICACHE_IDX_W-1:0] fetch_idx;
    logic [ICACHE_TAG_W-1:0] fetch_tag;
    logic                    arr_valid;
    logic [ICACHE_TAG_W-1:0] arr_tag;
    logic [31:0]             arr_data;
    logic                    lookup_hit_c;
    logic                    install_c;
    logic                    unused_pc_bits;

    assign fetch_idx      = fetch_pc[ICACHE_IDX_W+1:2];
    assign fetch_tag      = fetch_pc[31:ICACHE_IDX_W+2];
    assign unused_pc_bits = ^fetch_pc[1:0];

    icache_array u_array (
        .clk   (clk),
        .rst   (rst),
        .idx   (fetch_idx),
        .valid (arr_valid),
        .tag   (arr_tag),
        .data  (arr_data),
        .we    (install_c && rst),
        .widx  (miss_wa_q[ICACHE_IDX_W-1:0]),
        .wtag  (miss_wa_q[ICACHE_WA_W-1:ICACHE_IDX_W]),
        .wdata (inst_out)
    );

    assign lookup_hit_c = arr_valid && (arr_tag == fetch_tag);

    assign fetch_rdy  = rdy && fetch_req && (state_q == ICACHE_IDLE) && lookup_hit_c && !flush;
    assign fetch_inst = arr_data;
    // Drops in the inst_rdy/flush cycle so the controller never sees a stale request.
    assign inst_miss  = (state_q == ICACHE_MISS) && (!rdy || (!inst_rdy && !flush));
    assign pc         = {miss_wa_q, 2'b00};

    always_comb begin
        state_d   = state_q;
        miss_wa_d = miss_wa_q;
        install_c = 1'b0;
        if (rdy) begin
            case (state_q)
                ICACHE_IDLE: begin
                    if (fetch_req && !flush && !lookup_hit_c) begin
                        state_d   = ICACHE_MISS;
                        miss_wa_d = fetch_pc[31:2];
                    end
                end
                ICACHE_MISS: begin
                    // A coincident flush still installs: the refill address is valid.
                    install_c = inst_rdy;
                    if (inst_rdy || flush) begin
                        state_d = ICACHE_IDLE;
                    end
                end
                default: state_d = ICACHE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ICACHE_IDLE;
            miss_wa_q <= '0;
        end else begin
            state_q   <= state_d;
            miss_wa_q <= miss_wa_d;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized checking of icache against a line-map reference model.
module tb_icache;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        flush = 1'b0;
    logic        fetch_rdy;
    logic [31:0] fetch_inst;
    logic        inst_miss;
    logic [31:0] pc;
    logic        inst_rdy = 1'b0;
    logic [31:0] inst_out = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: line number -> cached word address and its data.
    logic [29:0] m_wa   [int];
    logic [31:0] m_data [int];
    bit          m_pending = 1'b0;
    logic [31:0] m_miss_pc = '0;
    bit          m_known = 1'b0;

    logic        o_fetch_rdy;
    logic [31:0] o_fetch_inst;
    logic        o_inst_miss;
    logic [31:0] o_pc;

    icache dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .fetch_req  (fetch_req),
        .fetch_pc   (fetch_pc),
        .flush      (flush),
        .fetch_rdy  (fetch_rdy),
        .fetch_inst (fetch_inst),
        .inst_miss  (inst_miss),
        .pc         (pc),
        .inst_rdy   (inst_rdy),
        .inst_out   (inst_out)
    );

    always #5 clk = ~clk;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % ICACHE_LINES);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int k;
        k = line_of(a);
        return m_wa.exists(k) && (m_wa[k] == a[31:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive after negedge, check settled outputs, then advance the model at posedge.
    task automatic cycle(input logic i_rst, input logic i_rdy, input logic i_req,
                         input logic [31:0] i_pc, input logic i_fl, input logic i_ir,
                         input logic [31:0] i_io);
        bit e_rdy;
        bit e_miss;
        int k;
        @(negedge clk);
        rst = i_rst; rdy = i_rdy; fetch_req = i_req; fetch_pc = i_pc;
        flush = i_fl; inst_rdy = i_ir; inst_out = i_io;
        #1;
        if (m_known) begin
            e_rdy  = i_rdy && i_req && !m_pending && m_hit(i_pc) && !i_fl;
            e_miss = m_pending && (!i_rdy || (!i_ir && !i_fl));
            chk("fetch_rdy", 32'(fetch_rdy), 32'(e_rdy));
            if (e_rdy) chk("fetch_inst", fetch_inst, m_data[line_of(i_pc)]);
            chk("inst_miss", 32'(inst_miss), 32'(e_miss));
            chk("pc", pc, m_miss_pc);
        end
        o_fetch_rdy = fetch_rdy; o_fetch_inst = fetch_inst;
        o_inst_miss = inst_miss; o_pc = pc;
        @(posedge clk);
        if (!i_rst) begin
            m_wa.delete(); m_data.delete();
            m_pending = 1'b0; m_miss_pc = '0; m_known = 1'b1;
        end else if (m_known && i_rdy) begin
            if (m_pending) begin
                if (i_ir) begin
                    k = line_of(m_miss_pc);
                    m_wa[k]   = m_miss_pc[31:2];
                    m_data[k] = i_io;
                end
                if (i_ir || i_fl) m_pending = 1'b0;
            end else if (i_req && !i_fl && !m_hit(i_pc)) begin
                m_pending = 1'b1;
                m_miss_pc = {i_pc[31:2], 2'b00};
            end
        end
    endtask

    initial begin
        int lat;
        bit was;
        logic r, fl, req, ir;
        logic [31:0] a, io;

        // reset
        cycle(0, 1, 0, 32'h0, 0, 0, 32'h0);
        cycle(0, 1, 0, 32'h0, 0, 0, 32'h0);
        // cold miss
        cycle(1, 1, 1, 32'h10, 0, 0, 32'h0);
        chk("reset_pc", o_pc, 32'h0);
        chk("cold_rdy", 32'(o_fetch_rdy), 32'h0);
        cycle(1, 1, 1, 32'h10, 0, 0, 32'h0);
        chk("cold_miss", 32'(o_inst_miss), 32'h1);
        chk("cold_pc", o_pc, 32'h10);
        cycle(1, 1, 1, 32'h10, 0, 1, 32'h0000_0513);
        chk("cold_miss_drop", 32'(o_inst_miss), 32'h0);
        cycle(1, 1, 1, 32'h10, 0, 0, 32'h0);
        chk("refill_hit", 32'(o_fetch_rdy), 32'h1);
        chk("refill_inst", o_fetch_inst, 32'h0000_0513);
        cycle(1, 1, 1, 32'h10, 0, 0, 32'h0);
        chk("hit_miss_low", 32'(o_inst_miss), 32'h0);
        // conflict eviction
        cycle(1, 1, 1, 32'h110, 0, 0, 32'h0);
        chk("conflict_rdy", 32'(o_fetch_rdy), 32'h0);
        cycle(1, 1, 1, 32'h110, 0, 0, 32'h0);
        cycle(1, 1, 1, 32'h110, 0, 1, 32'h0010_0093);
        cycle(1, 1, 1, 32'h110, 0, 0, 32'h0);
        chk("conflict_inst", o_fetch_inst, 32'h0010_0093);
        cycle(1, 1, 1, 32'h10, 0, 0, 32'h0);
        chk("evicted_rdy", 32'(o_fetch_rdy), 32'h0);
        cycle(1, 1, 1, 32'h10, 0, 1, 32'h0000_0513);
        cycle(1, 1, 1, 32'h10, 0, 0, 32'h0);
        // flush mid-refill
        cycle(1, 1, 1, 32'h20, 0, 0, 32'h0);
        cycle(1, 1, 1, 32'h20, 0, 0, 32'h0);
        cycle(1, 1, 1, 32'h20, 1, 0, 32'h0);
        chk("flush_miss_drop", 32'(o_inst_miss), 32'h0);
        cycle(1, 1, 1, 32'h20, 0, 0, 32'h0);
        chk("flush_no_install", 32'(o_fetch_rdy), 32'h0);
        cycle(1, 1, 1, 32'h20, 0, 1, 32'h0000_0297);
        // flush coincident with inst_rdy
        cycle(1, 1, 1, 32'h30, 0, 0, 32'h0);
        cycle(1, 1, 1, 32'h30, 0, 0, 32'h0);
        cycle(1, 1, 1, 32'h30, 1, 1, 32'hFFF0_0113);
        chk("flush_ir_rdy", 32'(o_fetch_rdy), 32'h0);
        cycle(1, 1, 1, 32'h30, 0, 0, 32'h0);
        chk("flush_ir_hit", 32'(o_fetch_rdy), 32'h1);
        chk("flush_ir_inst", o_fetch_inst, 32'hFFF0_0113);
        // rdy low during refill; a stray inst_rdy while frozen must not install
        cycle(1, 1, 1, 32'h40, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 1, 32'h40, 0, (i == 2), 32'hDEAD_BEEF);
            chk("frozen_miss", 32'(o_inst_miss), 32'h1);
            chk("frozen_pc", o_pc, 32'h40);
        end
        cycle(1, 1, 1, 32'h40, 0, 1, 32'h1234_5678);
        cycle(1, 1, 1, 32'h40, 0, 0, 32'h0);
        chk("frozen_inst", o_fetch_inst, 32'h1234_5678);

        // randomized traffic with a bench-side memory controller
        lat = 0;
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 11) == 0);
            req = ($urandom_range(0, 4) != 0);
            a   = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3));
            ir  = m_pending && (lat == 0);
            io  = 32'($urandom);
            was = m_pending;
            cycle(1, r, req, a, fl, ir, io);
            if (m_pending && !was) lat = $urandom_range(0, 3);
            else if (lat > 0) lat--;
        end

        // reset mid-refill
        cycle(1, 1, 1, 32'h50, 0, 0, 32'h0);
        cycle(1, 1, 1, 32'h54, 0, 0, 32'h0);
        cycle(0, 1, 0, 32'h0, 0, 0, 32'h0);
        cycle(1, 1, 0, 32'h10, 0, 0, 32'h0);
        chk("post_reset_miss", 32'(o_inst_miss), 32'h0);
        chk("post_reset_pc", o_pc, 32'h0);
        cycle(1, 1, 1, 32'h10, 0, 0, 32'h0);
        chk("post_reset_cold", 32'(o_fetch_rdy), 32'h0);
        cycle(1, 1, 0, 32'h10, 0, 0, 32'h0);
        chk("post_reset_refill", 32'(o_inst_miss), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
